one_or_two_stats: RTL and testbench

// - Downstream consumer of the one/two-hot classifier's registered outputs (vld, set_0, set_1, set_more_than_1).
// - Accumulates per-class sample counts over a fixed window of valid samples.
// - Publishes each completed window as a report over a valid/ready handshake.
// - The upstream stage has no back-pressure, so a report that cannot be delivered is dropped and flagged.

---
 rtl/one_or_two_stats.sv | 143 ++++++++++++++
 tb/tb_one_or_two_stats.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/one_or_two_stats.sv
// Windowed class statistics for the one/two-hot classifier: counts each sample class over WINDOW valid
// samples and offers the result as a single-slot valid/ready report. Optional drop counter: ONE_OR_TWO_STATS_DROP_CNT_EN.
module one_or_two_stats #(
    parameter int W_CNT  = 16,
    parameter int WINDOW = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic             in_set_0,
    input  logic             in_set_1,
    input  logic             in_set_more_than_1,
    input  logic             clr,
    output logic             rpt_vld,
    input  logic             rpt_rdy,
    output logic [W_CNT-1:0] rpt_cnt_0,
    output logic [W_CNT-1:0] rpt_cnt_1,
    output logic [W_CNT-1:0] rpt_cnt_more,
    output logic             rpt_err,
    output logic             ovf_r
`ifdef ONE_OR_TWO_STATS_DROP_CNT_EN
    ,
    output logic [W_CNT-1:0] drop_cnt
`endif
);

    generate
        if (WINDOW < 1 || WINDOW >= 2**W_CNT) begin : g_bad_window
            $error("one_or_two_stats: WINDOW must satisfy 1 <= WINDOW < 2**W_CNT");
        end
    endgenerate

    typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_t;

    logic [W_CNT-1:0] r_win_cnt;
    logic [W_CNT-1:0] r_acc_0;
    logic [W_CNT-1:0] r_acc_1;
    logic [W_CNT-1:0] r_acc_more;
    logic             r_err_acc;
    slot_t            r_slot;
    logic [W_CNT-1:0] r_rpt_cnt_0;
    logic [W_CNT-1:0] r_rpt_cnt_1;
    logic [W_CNT-1:0] r_rpt_cnt_more;
    logic             r_rpt_err;
    logic             r_ovf;

    logic             w_sample;
    logic             w_onehot;
    logic             w_done;
    logic             w_drain;
    logic             w_load;
    logic             w_drop;
    logic [W_CNT-1:0] w_cnt_0_next;
    logic [W_CNT-1:0] w_cnt_1_next;
    logic [W_CNT-1:0] w_cnt_more_next;
    logic             w_err_next;

    always_comb begin
        w_sample        = in_vld & ~clr;
        // Exactly one of three flags: odd parity excluding the all-three case.
        w_onehot        = (in_set_0 ^ in_set_1 ^ in_set_more_than_1)
                          & ~(in_set_0 & in_set_1 & in_set_more_than_1);
        w_done          = w_sample & (r_win_cnt == W_CNT'(WINDOW - 1));
        w_drain         = (r_slot == SLOT_FULL) & rpt_rdy;
        w_load          = w_done & ((r_slot == SLOT_EMPTY) | w_drain);
        w_drop          = w_done & (r_slot == SLOT_FULL) & ~rpt_rdy;
        w_cnt_0_next    = r_acc_0    + W_CNT'(w_sample & w_onehot & in_set_0);
        w_cnt_1_next    = r_acc_1    + W_CNT'(w_sample & w_onehot & in_set_1);
        w_cnt_more_next = r_acc_more + W_CNT'(w_sample & w_onehot & in_set_more_than_1);
        w_err_next      = r_err_acc | (w_sample & ~w_onehot);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win_cnt  <= '0;
            r_acc_0    <= '0;
            r_acc_1    <= '0;
            r_acc_more <= '0;
            r_err_acc  <= 1'b0;
        end else if (clr || w_done) begin
            // The completing sample lives only in the report; the next window starts empty.
            r_win_cnt  <= '0;
            r_acc_0    <= '0;
            r_acc_1    <= '0;
            r_acc_more <= '0;
            r_err_acc  <= 1'b0;
        end else if (w_sample) begin
            r_win_cnt  <= r_win_cnt + 1'b1;
            r_acc_0    <= w_cnt_0_next;
            r_acc_1    <= w_cnt_1_next;
            r_acc_more <= w_cnt_more_next;
            r_err_acc  <= w_err_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot         <= SLOT_EMPTY;
            r_rpt_cnt_0    <= '0;
            r_rpt_cnt_1    <= '0;
            r_rpt_cnt_more <= '0;
            r_rpt_err      <= 1'b0;
        end else begin
            case (r_slot)
                SLOT_EMPTY: if (w_load) r_slot <= SLOT_FULL;
                SLOT_FULL:  if (w_drain && !w_load) r_slot <= SLOT_EMPTY;
                default:    r_slot <= SLOT_EMPTY;
            endcase
            if (w_load) begin
                r_rpt_cnt_0    <= w_cnt_0_next;
                r_rpt_cnt_1    <= w_cnt_1_next;
                r_rpt_cnt_more <= w_cnt_more_next;
                r_rpt_err      <= w_err_next;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_ovf <= 1'b0;
        else if (clr)    r_ovf <= 1'b0;
        else if (w_drop) r_ovf <= 1'b1;
    end

`ifdef ONE_OR_TWO_STATS_DROP_CNT_EN
    logic [W_CNT-1:0] r_drop_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                               r_drop_cnt <= '0;
        else if (clr)                          r_drop_cnt <= '0;
        else if (w_drop && r_drop_cnt != '1)   r_drop_cnt <= r_drop_cnt + 1'b1;
    end

    assign drop_cnt = r_drop_cnt;
`endif

    assign rpt_vld      = (r_slot == SLOT_FULL);
    assign rpt_cnt_0    = r_rpt_cnt_0;
    assign rpt_cnt_1    = r_rpt_cnt_1;
    assign rpt_cnt_more = r_rpt_cnt_more;
    assign rpt_err      = r_rpt_err;
    assign ovf_r        = r_ovf;

endmodule

// File: tb/tb_one_or_two_stats.sv
// Self-checking bench for one_or_two_stats (WINDOW=4) against a per-window counting model.
module tb_one_or_two_stats;
    localparam int W   = 16;
    localparam int WIN = 4;
    localparam logic [2:0] C0 = 3'b001;
    localparam logic [2:0] C1 = 3'b010;
    localparam logic [2:0] CM = 3'b100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_vld = 1'b0, in_set_0 = 1'b0, in_set_1 = 1'b0, in_set_more_than_1 = 1'b0;
    logic clr = 1'b0, rpt_rdy = 1'b0;
    logic rpt_vld, rpt_err, ovf_r;
    logic [W-1:0] rpt_cnt_0, rpt_cnt_1, rpt_cnt_more;
`ifdef ONE_OR_TWO_STATS_DROP_CNT_EN
    logic [W-1:0] drop_cnt;
`endif

    always #5 clk = ~clk;

    one_or_two_stats #(.W_CNT(W), .WINDOW(WIN)) dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_set_0(in_set_0), .in_set_1(in_set_1),
        .in_set_more_than_1(in_set_more_than_1), .clr(clr), .rpt_vld(rpt_vld), .rpt_rdy(rpt_rdy),
        .rpt_cnt_0(rpt_cnt_0), .rpt_cnt_1(rpt_cnt_1), .rpt_cnt_more(rpt_cnt_more),
        .rpt_err(rpt_err), .ovf_r(ovf_r)
`ifdef ONE_OR_TWO_STATS_DROP_CNT_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: samples seen in the open window, its class tallies, and the one report slot.
    int m_n, m_c0, m_c1, m_cm, m_drop;
    bit m_err, m_full, m_rerr, m_ovf;
    int m_r0, m_r1, m_rm;

    task automatic model_reset();
        m_n = 0; m_c0 = 0; m_c1 = 0; m_cm = 0; m_err = 0;
        m_full = 0; m_r0 = 0; m_r1 = 0; m_rm = 0; m_rerr = 0; m_ovf = 0; m_drop = 0;
    endtask

    task automatic model_clock();
        bit drained = m_full && rpt_rdy;
        bit loaded  = 0;
        int k;
        if (clr) begin
            m_n = 0; m_c0 = 0; m_c1 = 0; m_cm = 0; m_err = 0; m_ovf = 0; m_drop = 0;
        end else if (in_vld) begin
            k = int'(in_set_0) + int'(in_set_1) + int'(in_set_more_than_1);
            if (k == 1) begin
                if (in_set_0) m_c0++;
                if (in_set_1) m_c1++;
                if (in_set_more_than_1) m_cm++;
            end else begin
                m_err = 1;
            end
            m_n++;
            if (m_n == WIN) begin
                if (!m_full || drained) begin
                    m_r0 = m_c0; m_r1 = m_c1; m_rm = m_cm; m_rerr = m_err; loaded = 1;
                end else begin
                    m_ovf = 1;
                    if (m_drop < 65535) m_drop++;
                end
                m_n = 0; m_c0 = 0; m_c1 = 0; m_cm = 0; m_err = 0;
            end
        end
        if (loaded) m_full = 1;
        else if (drained) m_full = 0;
    endtask

    function automatic logic [50:0] exp_vec();
        if (m_full) return {1'b1, W'(m_r0), W'(m_r1), W'(m_rm), m_rerr, m_ovf};
        return {1'b0, 48'd0, 1'b0, m_ovf};
    endfunction

    function automatic logic [50:0] got_vec();
        if (rpt_vld === 1'b1) return {1'b1, rpt_cnt_0, rpt_cnt_1, rpt_cnt_more, rpt_err, ovf_r};
        return {rpt_vld, 48'd0, 1'b0, ovf_r};
    endfunction

    // Drive one cycle of inputs, let the DUT and model take the edge, then settle 1 time unit.
    task automatic cycle(input bit v, input logic [2:0] cls, input bit c, input bit r);
        in_vld = v;
        {in_set_more_than_1, in_set_1, in_set_0} = cls;
        clr = c;
        rpt_rdy = r;
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        rst = 1'b1;
        #3;
        n_checks++;
        if ({rpt_vld, rpt_cnt_0, rpt_cnt_1, rpt_cnt_more, rpt_err, ovf_r} !== 51'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%h required=0", {rpt_vld, rpt_cnt_0, rpt_cnt_1, rpt_cnt_more, rpt_err, ovf_r});
        end
        @(negedge clk);
        rst = 1'b0;
        cycle(0, 3'b000, 0, 0);
        n_checks++;
        if (got_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_idle got=%h required=%h", got_vec(), exp_vec());
        end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        logic [2:0] cls [4] = '{C0, C1, CM, C1};
        for (int i = 0; i < 4; i++) begin
            cycle(1, cls[i], 0, 1);
            n_checks++;
            if (got_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL basic_s%0d got=%h required=%h", i, got_vec(), exp_vec());
            end
        end
        n_checks++;
        if ({rpt_vld, rpt_cnt_0, rpt_cnt_1, rpt_cnt_more, rpt_err} !== {1'b1, 16'd1, 16'd2, 16'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_report got vld=%b %0d/%0d/%0d err=%b required 1 1/2/1 err=0",
                     rpt_vld, rpt_cnt_0, rpt_cnt_1, rpt_cnt_more, rpt_err);
        end
        cycle(0, 3'b000, 0, 1);
        n_checks++;
        if (rpt_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_one_cycle got rpt_vld=%b required 0", rpt_vld);
        end
        $display("test_basic done");
    endtask

    task automatic test_gaps();
        logic [2:0] cls [4] = '{C0, C1, CM, C1};
        for (int i = 0; i < 4; i++) begin
            cycle(0, CM, 0, 1);
            cycle(0, C0, 0, 1);
            cycle(1, cls[i], 0, 1);
            n_checks++;
            if (got_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL gaps_s%0d got=%h required=%h", i, got_vec(), exp_vec());
            end
        end
        n_checks++;
        if ({rpt_vld, rpt_cnt_0, rpt_cnt_1, rpt_cnt_more} !== {1'b1, 16'd1, 16'd2, 16'd1}) begin
            n_fail++;
            $display("FAIL gaps_report got vld=%b %0d/%0d/%0d required 1 1/2/1",
                     rpt_vld, rpt_cnt_0, rpt_cnt_1, rpt_cnt_more);
        end
        cycle(0, 3'b000, 0, 1);
        $display("test_gaps done");
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 8; i++) begin
            cycle(1, C0, 0, 0);
            n_checks++;
            if (got_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL ovf_s%0d got=%h required=%h", i, got_vec(), exp_vec());
            end
        end
        n_checks++;
        if ({rpt_vld, rpt_cnt_0, rpt_cnt_1, rpt_cnt_more, ovf_r} !== {1'b1, 16'd4, 16'd0, 16'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL ovf_held got vld=%b %0d/%0d/%0d ovf=%b required 1 4/0/0 ovf=1",
                     rpt_vld, rpt_cnt_0, rpt_cnt_1, rpt_cnt_more, ovf_r);
        end
`ifdef ONE_OR_TWO_STATS_DROP_CNT_EN
        n_checks++;
        if (drop_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL ovf_drop_cnt got=%0d required=1", drop_cnt);
        end
`endif
        $display("test_overflow done");
    endtask

    task automatic test_back_to_back();
        cycle(0, 3'b000, 1, 0);
        n_checks++;
        if ({rpt_vld, rpt_cnt_0, ovf_r} !== {1'b1, 16'd4, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_clr got vld=%b cnt0=%0d ovf=%b required 1 4 0", rpt_vld, rpt_cnt_0, ovf_r);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1, C1, 0, i == 3);
            n_checks++;
            if (got_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL b2b_s%0d got=%h required=%h", i, got_vec(), exp_vec());
            end
        end
        n_checks++;
        if ({rpt_vld, rpt_cnt_0, rpt_cnt_1, rpt_cnt_more, ovf_r} !== {1'b1, 16'd0, 16'd4, 16'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_reload got vld=%b %0d/%0d/%0d ovf=%b required 1 0/4/0 ovf=0",
                     rpt_vld, rpt_cnt_0, rpt_cnt_1, rpt_cnt_more, ovf_r);
        end
        cycle(0, 3'b000, 0, 1);
        $display("test_back_to_back done");
    endtask

    task automatic test_err();
        cycle(1, 3'b011, 0, 1);
        for (int i = 0; i < 3; i++) cycle(1, C1, 0, 1);
        n_checks++;
        if ({rpt_vld, rpt_cnt_0, rpt_cnt_1, rpt_cnt_more, rpt_err} !== {1'b1, 16'd0, 16'd3, 16'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL err_report got vld=%b %0d/%0d/%0d err=%b required 1 0/3/0 err=1",
                     rpt_vld, rpt_cnt_0, rpt_cnt_1, rpt_cnt_more, rpt_err);
        end
        for (int i = 0; i < 4; i++) cycle(1, C0, 0, 1);
        n_checks++;
        if ({rpt_vld, rpt_cnt_0, rpt_err} !== {1'b1, 16'd4, 1'b0}) begin
            n_fail++;
            $display("FAIL err_next_window got vld=%b cnt0=%0d err=%b required 1 4 0", rpt_vld, rpt_cnt_0, rpt_err);
        end
        cycle(0, 3'b000, 0, 1);
        $display("test_err done");
    endtask

    task automatic test_clr();
        cycle(1, C0, 0, 1);
        cycle(1, C1, 0, 1);
        cycle(1, C0, 1, 1);
        for (int i = 0; i < 4; i++) cycle(1, CM, 0, 1);
        n_checks++;
        if ({rpt_vld, rpt_cnt_0, rpt_cnt_1, rpt_cnt_more, rpt_err} !== {1'b1, 16'd0, 16'd0, 16'd4, 1'b0}) begin
            n_fail++;
            $display("FAIL clr_report got vld=%b %0d/%0d/%0d err=%b required 1 0/0/4 err=0",
                     rpt_vld, rpt_cnt_0, rpt_cnt_1, rpt_cnt_more, rpt_err);
        end
        cycle(0, 3'b000, 0, 1);
        $display("test_clr done");
    endtask

    task automatic test_rst_mid();
        for (int i = 0; i < 6; i++) cycle(1, C1, 0, 0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if ({rpt_vld, rpt_cnt_0, rpt_cnt_1, rpt_cnt_more, rpt_err, ovf_r} !== 51'd0) begin
            n_fail++;
            $display("FAIL rst_async got vld=%b cnt1=%0d ovf=%b required all 0", rpt_vld, rpt_cnt_1, ovf_r);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1, C0, 0, 1);
        n_checks++;
        if (rpt_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_fresh_window got rpt_vld=%b required 0", rpt_vld);
        end
        cycle(1, C0, 0, 1);
        n_checks++;
        if ({rpt_vld, rpt_cnt_0} !== {1'b1, 16'd4}) begin
            n_fail++;
            $display("FAIL rst_first_report got vld=%b cnt0=%0d required 1 4", rpt_vld, rpt_cnt_0);
        end
        $display("test_rst_mid done");
    endtask

    task automatic test_random();
        int errs_before = n_fail;
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                  $urandom_range(0, 40) == 0, $urandom_range(0, 2) == 0);
            n_checks++;
            if (got_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_c%0d got=%h required=%h", i, got_vec(), exp_vec());
            end
`ifdef ONE_OR_TWO_STATS_DROP_CNT_EN
            n_checks++;
            if (drop_cnt !== W'(m_drop)) begin
                n_fail++;
                $display("FAIL random_drop_c%0d got=%0d required=%0d", i, drop_cnt, m_drop);
            end
`endif
        end
        $display("test_random done, %0d new failures", n_fail - errs_before);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_overflow();
        test_back_to_back();
        test_err();
        test_clr();
        test_rst_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
